// File: rtl/mem_req_to_sram.sv
// mem_req_to_sram: valid/ready memory requests to a req/gnt SRAM port with fixed-latency, valid-only responses
module mem_req_to_sram #(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned Latency      = 1,
  parameter bit          SpillReq     = 1'b0,
  parameter bit          RegisterResp = 1'b0,
  localparam int unsigned BeWidth     = DataWidth / 8,
  localparam int unsigned OutWidth    = $clog2(Latency + RegisterResp + 2)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_we_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  output logic [DataWidth-1:0] resp_rdata_o,
  output logic                 resp_valid_o,
  output logic                 sram_req_o,
  input  logic                 sram_gnt_i,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic                 sram_we_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i,
  output logic [OutWidth-1:0]  outstanding_o
);

  if (Latency < 1) begin : g_bad_latency
    $error("mem_req_to_sram: Latency must be at least 1");
  end
  if (DataWidth % 8 != 0) begin : g_bad_width
    $error("mem_req_to_sram: DataWidth must be a multiple of 8");
  end

  logic                 beat;
  logic [Latency-1:0]   vld_q;
  logic [Latency-1:0]   we_q;
  logic                 pipe_vld;
  logic [DataWidth-1:0] pipe_data;

  if (SpillReq) begin : g_spill
    typedef enum logic {EMPTY, FULL} spill_state_e;
    spill_state_e         state_q, state_d;
    logic                 hs;
    logic [AddrWidth-1:0] addr_q;
    logic                 we_r;
    logic [DataWidth-1:0] wdata_q;
    logic [BeWidth-1:0]   be_q;
    assign req_ready_o  = (state_q == EMPTY) || sram_gnt_i;
    assign hs           = req_valid_i && req_ready_o;
    assign sram_req_o   = state_q == FULL;
    assign sram_addr_o  = addr_q;
    assign sram_we_o    = we_r;
    assign sram_wdata_o = wdata_q;
    assign sram_be_o    = be_q;
    // A handshake always (re)fills the slot; a grant without a refill drains it
    always_comb begin
      state_d = state_q;
      if (hs) state_d = FULL;
      else if (state_q == FULL && sram_gnt_i) state_d = EMPTY;
    end
    // Slot state and payload capture on handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= EMPTY;
        addr_q  <= '0;
        we_r    <= 1'b0;
        wdata_q <= '0;
        be_q    <= '0;
      end else begin
        state_q <= state_d;
        if (hs) begin
          addr_q  <= req_addr_i;
          we_r    <= req_we_i;
          wdata_q <= req_wdata_i;
          be_q    <= req_be_i;
        end
      end
    end
  end else begin : g_pass
    assign req_ready_o  = sram_gnt_i;
    assign sram_req_o   = req_valid_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_we_o    = req_we_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;
  end

  assign beat      = sram_req_o && sram_gnt_i;
  assign pipe_vld  = vld_q[Latency-1];
  assign pipe_data = (pipe_vld && !we_q[Latency-1]) ? sram_rdata_i : '0;

  // Token pipe: one {valid, we} per granted beat, advancing every cycle to line up with rdata
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      we_q  <= '0;
    end else begin
      vld_q <= Latency'({vld_q, beat});
      we_q  <= Latency'({we_q, sram_we_o});
    end
  end

  if (RegisterResp) begin : g_resp_reg
    // Extra response stage to cut the sram_rdata_i path
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        resp_valid_o <= 1'b0;
        resp_rdata_o <= '0;
      end else begin
        resp_valid_o <= pipe_vld;
        resp_rdata_o <= pipe_data;
      end
    end
  end else begin : g_resp_comb
    assign resp_valid_o = pipe_vld;
    assign resp_rdata_o = pipe_data;
  end

  // Granted-but-unanswered count; bounded by Latency+RegisterResp so it cannot wrap
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) outstanding_o <= '0;
    else outstanding_o <= outstanding_o + OutWidth'(beat) - OutWidth'(resp_valid_o);
  end

endmodule

// File: tb/tb_mem_req_to_sram.sv
// tb_mem_req_to_sram: directed and randomized checks of three mem_req_to_sram configurations
module tb_mem_req_to_sram;

  localparam logic [31:0] IDLE = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_valid = 1'b0;
  logic        gnt_a = 1'b0, gnt_b = 1'b0, gnt_c = 1'b0;

  logic        rdy_a, rdy_b, rdy_c, rvalid_a, rvalid_b, rvalid_c;
  logic        sreq_a, sreq_b, sreq_c, swe_a, swe_b, swe_c;
  logic [31:0] rdata_a, rdata_b, rdata_c, saddr_a, saddr_b, saddr_c;
  logic [31:0] swdata_a, swdata_b, swdata_c, srdata_a, srdata_b, srdata_c;
  logic [3:0]  sbe_a, sbe_b, sbe_c;
  logic [1:0]  outst_a, outst_b;
  logic [2:0]  outst_c;
  logic [31:0]       pa;
  logic [1:0][31:0]  pb;
  logic [2:0][31:0]  pc;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEAF;
  endfunction

  mem_req_to_sram #(.Latency(1), .SpillReq(1'b0), .RegisterResp(1'b0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_addr_i(req_addr), .req_we_i(req_we), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .req_valid_i(req_valid), .req_ready_o(rdy_a), .resp_rdata_o(rdata_a),
    .resp_valid_o(rvalid_a), .sram_req_o(sreq_a), .sram_gnt_i(gnt_a), .sram_addr_o(saddr_a),
    .sram_we_o(swe_a), .sram_wdata_o(swdata_a), .sram_be_o(sbe_a), .sram_rdata_i(srdata_a),
    .outstanding_o(outst_a));

  mem_req_to_sram #(.Latency(2), .SpillReq(1'b1), .RegisterResp(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_addr_i(req_addr), .req_we_i(req_we), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .req_valid_i(req_valid), .req_ready_o(rdy_b), .resp_rdata_o(rdata_b),
    .resp_valid_o(rvalid_b), .sram_req_o(sreq_b), .sram_gnt_i(gnt_b), .sram_addr_o(saddr_b),
    .sram_we_o(swe_b), .sram_wdata_o(swdata_b), .sram_be_o(sbe_b), .sram_rdata_i(srdata_b),
    .outstanding_o(outst_b));

  mem_req_to_sram #(.Latency(3), .SpillReq(1'b1), .RegisterResp(1'b1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_addr_i(req_addr), .req_we_i(req_we), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .req_valid_i(req_valid), .req_ready_o(rdy_c), .resp_rdata_o(rdata_c),
    .resp_valid_o(rvalid_c), .sram_req_o(sreq_c), .sram_gnt_i(gnt_c), .sram_addr_o(saddr_c),
    .sram_we_o(swe_c), .sram_wdata_o(swdata_c), .sram_be_o(sbe_c), .sram_rdata_i(srdata_c),
    .outstanding_o(outst_c));

  // SRAM models: data is a fixed function of the granted address, delivered Latency cycles later
  always @(posedge clk) begin
    pa <= (sreq_a && gnt_a) ? sram_word(saddr_a) : IDLE;
    pb <= {pb[0], (sreq_b && gnt_b) ? sram_word(saddr_b) : IDLE};
    pc <= {pc[1:0], (sreq_c && gnt_c) ? sram_word(saddr_c) : IDLE};
  end
  assign srdata_a = pa;
  assign srdata_b = pb[1];
  assign srdata_c = pc[2];

  task automatic do_reset;
    req_valid = 0; req_we = 0; gnt_a = 0; gnt_b = 0; gnt_c = 0;
    @(negedge clk); #2 rst_n = 0;
    @(negedge clk); #2 rst_n = 1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_tests++;
    if ({rdy_a, rdy_b, rdy_c} !== 3'b011) begin
      n_fail++; $display("FAIL reset_ready: got %b want 011", {rdy_a, rdy_b, rdy_c});
    end
    n_tests++;
    if ({sreq_a, sreq_b, sreq_c, rvalid_a, rvalid_b, rvalid_c} !== 6'b0) begin
      n_fail++; $display("FAIL reset_req_valid: got %b want 000000", {sreq_a, sreq_b, sreq_c, rvalid_a, rvalid_b, rvalid_c});
    end
    n_tests++;
    if ({rdata_a, rdata_b, rdata_c} !== 96'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", {rdata_a, rdata_b, rdata_c});
    end
    n_tests++;
    if ({outst_a, outst_b, outst_c} !== 7'h0) begin
      n_fail++; $display("FAIL reset_outstanding: got %h want 0", {outst_a, outst_b, outst_c});
    end
    gnt_a = 1; #1;
    n_tests++;
    if (rdy_a !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_gnt: got %b want 1", rdy_a);
    end
    gnt_a = 0;
    @(negedge clk); #2 rst_n = 1;
  endtask

  task automatic test_single_read;
    do_reset;
    @(posedge clk); #1 req_addr = 32'h40; req_we = 0; req_valid = 1; gnt_a = 1;
    @(negedge clk);
    n_tests++;
    if ({sreq_a, rdy_a, rvalid_a, swe_a, saddr_a, outst_a} !== {4'b1100, 32'h40, 2'd0}) begin
      n_fail++; $display("FAIL read_c0: got %h want %h", {sreq_a, rdy_a, rvalid_a, swe_a, saddr_a, outst_a}, {4'b1100, 32'h40, 2'd0});
    end
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    n_tests++;
    if ({rvalid_a, rdata_a, outst_a} !== {1'b1, 32'hDEAD_BEEF, 2'd1}) begin
      n_fail++; $display("FAIL read_c1: got %h want %h", {rvalid_a, rdata_a, outst_a}, {1'b1, 32'hDEAD_BEEF, 2'd1});
    end
    @(negedge clk);
    n_tests++;
    if ({rvalid_a, outst_a} !== 3'b000) begin
      n_fail++; $display("FAIL read_c2: got %b want 000", {rvalid_a, outst_a});
    end
  endtask

  task automatic test_write_ack;
    do_reset;
    @(posedge clk); #1 req_addr = 32'h80; req_we = 1; req_wdata = 32'h1234_5678; req_be = 4'b0011; req_valid = 1; gnt_a = 1;
    @(negedge clk);
    n_tests++;
    if ({sreq_a, swe_a, sbe_a, swdata_a, saddr_a} !== {2'b11, 4'b0011, 32'h1234_5678, 32'h80}) begin
      n_fail++; $display("FAIL write_sram: got %h want %h", {sreq_a, swe_a, sbe_a, swdata_a, saddr_a}, {2'b11, 4'b0011, 32'h1234_5678, 32'h80});
    end
    @(posedge clk); #1 req_valid = 0; req_we = 0;
    @(negedge clk);
    n_tests++;
    if ({rvalid_a, rdata_a} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL write_ack: got %h want %h", {rvalid_a, rdata_a}, {1'b1, 32'h0});
    end
  endtask

  task automatic test_back_to_back;
    logic [32:0] e;
    do_reset;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1 req_valid = k < 8; req_we = 0; req_addr = 32'h200 + 32'(k * 4); gnt_a = 1;
      @(negedge clk);
      e = (k >= 1 && k <= 8) ? {1'b1, sram_word(32'h200 + 32'((k - 1) * 4))} : 33'h0;
      n_tests++;
      if ({rvalid_a, rdata_a} !== e) begin
        n_fail++; $display("FAIL b2b_cycle%0d: got %h want %h", k, {rvalid_a, rdata_a}, e);
      end
    end
  endtask

  task automatic test_grant_stall;
    int          v[8]   = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [31:0] a[8]   = '{32'h100, 32'h104, 32'h104, 32'h104, 0, 0, 0, 0};
    int          g[8]   = '{0, 0, 0, 1, 1, 0, 0, 0};
    int          ry[8]  = '{1, 0, 0, 1, 1, 1, 1, 1};
    int          sr[8]  = '{0, 1, 1, 1, 1, 0, 0, 0};
    logic [31:0] sa[8]  = '{0, 32'h100, 32'h100, 32'h100, 32'h104, 0, 0, 0};
    int          rv[8]  = '{0, 0, 0, 0, 0, 1, 1, 0};
    logic [31:0] rd[8]  = '{0, 0, 0, 0, 0, 32'h100 ^ 32'hDEAD_BEAF, 32'h104 ^ 32'hDEAD_BEAF, 0};
    int          os[8]  = '{0, 0, 0, 0, 1, 2, 1, 0};
    logic [68:0] got, e;
    do_reset;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1 req_valid = v[k] != 0; req_we = 0; req_addr = a[k]; gnt_b = g[k] != 0;
      @(negedge clk);
      got = {rdy_b, sreq_b, sreq_b ? saddr_b : 32'h0, rvalid_b, rdata_b, outst_b};
      e = {ry[k] != 0, sr[k] != 0, sa[k], rv[k] != 0, rd[k], 2'(os[k])};
      n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL stall_cycle%0d: got %h want %h", k, got, e);
      end
    end
  endtask

  task automatic test_reset_midflight;
    bit          seen = 0;
    int          at = -1;
    logic [31:0] d = '0;
    do_reset;
    gnt_b = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 req_valid = 1; req_we = 0; req_addr = 32'h400 + 32'(k * 4);
      @(negedge clk);
    end
    @(posedge clk); #1 req_addr = 32'h40C; gnt_b = 0;
    @(negedge clk);
    n_tests++;
    if ({sreq_b, rdy_b, rvalid_b, outst_b, rdata_b} !== {3'b101, 2'd2, 32'h400 ^ 32'hDEAD_BEAF}) begin
      n_fail++; $display("FAIL midflight_pre: got %h want %h", {sreq_b, rdy_b, rvalid_b, outst_b, rdata_b}, {3'b101, 2'd2, 32'h400 ^ 32'hDEAD_BEAF});
    end
    #2 rst_n = 0;
    #1;
    n_tests++;
    if ({rvalid_b, sreq_b, rdy_b, outst_b, rdata_b} !== {3'b001, 2'd0, 32'h0}) begin
      n_fail++; $display("FAIL midflight_async: got %h want %h", {rvalid_b, sreq_b, rdy_b, outst_b, rdata_b}, {3'b001, 2'd0, 32'h0});
    end
    req_valid = 0;
    @(negedge clk); #2 rst_n = 1; gnt_b = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rvalid_b !== 1'b0 || outst_b !== 2'd0) seen = 1;
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL midflight_quiet: got stray activity want none");
    end
    @(posedge clk); #1 req_valid = 1; req_addr = 32'h500;
    @(negedge clk);
    @(posedge clk); #1 req_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (rvalid_b === 1'b1 && at < 0) begin
        at = k; d = rdata_b;
      end
    end
    n_tests++;
    if (at != 3 || d !== (32'h500 ^ 32'hDEAD_BEAF)) begin
      n_fail++; $display("FAIL midflight_after: got cycle %0d data %h want cycle 3 data %h", at, d, 32'h500 ^ 32'hDEAD_BEAF);
    end
  endtask

  task automatic test_stream(input int n);
    logic [31:0] eq[$];
    int          gq[$];
    logic [31:0] e;
    int          g;
    int sent = 0, got = 0, cnt = 0, cyc = 0, f0 = n_fail;
    bit hs = 0;
    do_reset;
    while (got < n && cyc < 4 * n + 200 && n_fail - f0 < 20) begin
      @(posedge clk); #1;
      if (!req_valid || hs) begin
        req_valid = (sent < n) && ($urandom_range(0, 3) != 0);
        if (req_valid) begin
          req_we = 1'($urandom_range(0, 1)); req_addr = $urandom & 32'hFFFF_FFFC;
          req_wdata = $urandom; req_be = 4'($urandom); sent++;
        end
      end
      gnt_c = $urandom_range(0, 3) != 0;
      @(negedge clk);
      hs = req_valid && rdy_c;
      n_tests++;
      if (outst_c !== 3'(cnt) || outst_c > 3'd4) begin
        n_fail++; $display("FAIL stream_outstanding cycle %0d: got %0d want %0d", cyc, outst_c, cnt);
      end
      if (hs) eq.push_back(req_we ? 32'h0 : sram_word(req_addr));
      if (sreq_c && gnt_c) begin
        gq.push_back(cyc); cnt++;
      end
      if (rvalid_c) begin
        n_tests++;
        if (eq.size() == 0 || gq.size() == 0) begin
          n_fail++; $display("FAIL stream_extra cycle %0d: got response want none", cyc);
        end else begin
          e = eq.pop_front(); g = gq.pop_front();
          if (rdata_c !== e || cyc - g != 4) begin
            n_fail++; $display("FAIL stream_resp cycle %0d: got %h lat %0d want %h lat 4", cyc, rdata_c, cyc - g, e);
          end
        end
        got++; cnt--;
      end
      cyc++;
    end
    n_tests++;
    if (got != n || eq.size() != 0) begin
      n_fail++; $display("FAIL stream_count: got %0d responses want %0d", got, n);
    end
    req_valid = 0;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_write_ack;
    test_back_to_back;
    test_grant_stall;
    test_reset_midflight;
    test_stream(10000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_to_sram.md
# mem_req_to_sram

Memory-side adapter that sits directly downstream of `stream_to_mem`. It accepts valid/ready memory requests and drives a banked SRAM port with a request/grant handshake and a fixed read latency. It returns exactly one response pulse per accepted request on a valid-only response channel with no backpressure, which is the interface `stream_to_mem` expects on `mem_resp_*`. An optional spill register decouples `req_ready_o` from `sram_gnt_i`. An optional response register breaks the `sram_rdata_i` timing path.

## Interface
- `AddrWidth`, 32, request/SRAM address width.
- `DataWidth`, 32, data width; must be a multiple of 8.
- `Latency`, 1, cycles from SRAM grant to valid `sram_rdata_i`; ≥1; elaboration error if 0.
- `SpillReq`, 1'b0, 1 = insert a 1-entry request register between the request port and the SRAM port.
- `RegisterResp`, 1'b0, 1 = register the response, adding one cycle of latency.
- `clk_i`, in, 1, clock; all state is on its rising edge.
- `rst_ni`, in, 1, asynchronous active-low reset.
- `req_addr_i`, in, AddrWidth, request address.
- `req_we_i`, in, 1, 1 = write, 0 = read.
- `req_wdata_i`, in, DataWidth, write data.
- `req_be_i`, in, DataWidth/8, byte enables.
- `req_valid_i`, in, 1, request valid.
- `req_ready_o`, out, 1, request accepted when high together with `req_valid_i`.
- `resp_rdata_o`, out, DataWidth, read data; '0 for write responses.
- `resp_valid_o`, out, 1, one-cycle response pulse per request; never backpressured.
- `sram_req_o`, out, 1, SRAM request.
- `sram_gnt_i`, in, 1, SRAM grant.
- `sram_addr_o`, out, AddrWidth, SRAM address.
- `sram_we_o`, out, 1, SRAM write enable.
- `sram_wdata_o`, out, DataWidth, SRAM write data.
- `sram_be_o`, out, DataWidth/8, SRAM byte enables.
- `sram_rdata_i`, in, DataWidth, SRAM read data, valid `Latency` cycles after grant.
- `outstanding_o`, out, $clog2(Latency+RegisterResp+2), number of granted requests whose response has not yet pulsed.

## Operation
- **SpillReq=0**
  - `sram_req_o` = `req_valid_i`.
  - SRAM address/we/wdata/be outputs = request inputs.
  - `req_ready_o` = `sram_gnt_i`. This path is combinational.
- **SpillReq=1**
  - One register plus a `full` flag.
  - EMPTY: `req_ready_o`=1. A handshake loads the register and moves to FULL.
  - FULL: `sram_req_o`=1 and the SRAM outputs come from the register. `req_ready_o` = `sram_gnt_i`.
  - FULL with grant and a new handshake: reload the register and stay FULL.
  - FULL with grant and no handshake: go to EMPTY.
  - Requests never fall through combinationally.
- **Granted beat**
  - A granted beat is `sram_req_o && sram_gnt_i`.
  - Each granted beat shifts a token {valid=1, we} into a `Latency`-deep shift register. Tokens advance every cycle.
  - `resp_valid_o` = valid bit of the last stage.
  - `resp_rdata_o` = `sram_rdata_i` masked to '0 when the token's we=1.
- **RegisterResp=1**: valid and masked rdata pass through one more flop.
- **outstanding_o**: +1 on a granted beat, −1 on `resp_valid_o`. Both in the same cycle leaves it unchanged. It cannot overflow: it is bounded by `Latency+RegisterResp`.
- Request-side stability: once `req_valid_i` is high, it and the payload are held until the handshake. The block does not check this.
- **Reset (async, mid-operation)**
  - Clears the spill register to EMPTY and clears the shift register and response flop.
  - In-flight responses are dropped.
  - Outputs go to reset values immediately.

## Timing
- Reset values: `req_ready_o` = 0 if SpillReq=0 and `sram_gnt_i` low, otherwise 1 (EMPTY). `resp_valid_o`=0, `resp_rdata_o`='0, `sram_req_o`=0, `outstanding_o`=0.
- Response latency, measured from the granted beat in cycle T: `resp_valid_o` high in cycle T+Latency+RegisterResp.
- Request-to-SRAM latency: SpillReq=0 gives 0 cycles; SpillReq=1 gives 1 cycle.
- Throughput: one request per cycle under continuous grant, for every parameter combination.
- Response order equals request order; there is no ID.
- Back-to-back grants produce back-to-back `resp_valid_o` pulses.

## Test plan
- **Single read, defaults:**
  - Stimulus: addr 0x40, SRAM model returns 0xDEADBEEF at Latency=1, gnt=1.
  - Response: `sram_req_o` in cycle 0, `resp_valid_o` in cycle 1 with 0xDEADBEEF, `outstanding_o` 1→0.
- **Write ack:**
  - Stimulus: we=1, wdata 0x12345678, be 4'b0011.
  - Response: SRAM sees the same be/wdata; `resp_valid_o` pulses after 1 cycle with `resp_rdata_o`=0.
- **Grant stalls, SpillReq=1, Latency=2:**
  - Stimulus: gnt low for 3 cycles while 2 requests are issued.
  - Response: the first request is held in the register and `req_ready_o` stays low while FULL and ungranted. No loss or duplication; responses arrive in order exactly 2 cycles after each grant.
- **Streaming, RegisterResp=1, Latency=3:**
  - Stimulus: 10000 random reads/writes, random gnt.
  - Response: per-request scoreboard matches. `outstanding_o` ≤ 4 and equals the model count every cycle.
- **Back-to-back:**
  - Stimulus: 8 consecutive requests with gnt held high.
  - Response: 8 consecutive `resp_valid_o` cycles, no bubbles.
- **Reset mid-flight:**
  - Stimulus: assert `rst_ni` low asynchronously (not on an edge) with 2 responses in flight and the spill register FULL.
  - Response: `resp_valid_o`, `sram_req_o` and `outstanding_o` drop to 0 immediately. No pulses after release until new requests are granted.
